// File: rtl/vmask_pkg.sv
// Shared types and derived widths for the vmask_expand block.
package vmask_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   // One mask bit per byte lane of the request data word.
   function automatic int mask_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/vmask_thermo.sv
// Remaining-count to thermometer mask: bit i is set while more than i elements remain.
module vmask_thermo
   import vmask_pkg::*;
#(
   parameter int MASK_W      = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic [COUNT_WIDTH-1:0] rem,
   output logic [MASK_W-1:0]      mask
);

   always_comb begin
      mask = '0;
      for (int i = 0; i < MASK_W; i++) begin
         mask[i] = (rem > COUNT_WIDTH'(i));
      end
   end

endmodule

// File: rtl/vmask_expand.sv
// Expands an (active count, total count) request into a stream of thermometer mask beats.
// Optional feature: define VMASK_EXPAND_INVERT_EN to add in_invert (complement active bits within total).
module vmask_expand
   import vmask_pkg::*;
#(
   parameter  int REQ_DATA_WIDTH = 64,
   parameter  int COUNT_WIDTH    = 16,
   localparam int MASK_W         = mask_width(REQ_DATA_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [COUNT_WIDTH-1:0] in_count,
   input  logic [COUNT_WIDTH-1:0] in_total,
`ifdef VMASK_EXPAND_INVERT_EN
   input  logic                   in_invert,
`endif
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [MASK_W-1:0]      out_m0,
   output logic                   out_last
);

   localparam logic [COUNT_WIDTH-1:0] MW_C = COUNT_WIDTH'(MASK_W);

   function automatic logic [COUNT_WIDTH-1:0] sat_sub(input logic [COUNT_WIDTH-1:0] v);
      return (v > MW_C) ? (v - MW_C) : '0;
   endfunction

   state_e                  state_q, state_d;
   logic [COUNT_WIDTH-1:0]  rem_act_q, rem_act_d;
   logic [COUNT_WIDTH-1:0]  rem_tot_q, rem_tot_d;
   logic [MASK_W-1:0]       out_m0_q, out_m0_d;
   logic                    out_last_q, out_last_d;
   logic                    invert_q, invert_d;

   logic                    accept;
   logic                    load;
   logic                    advance;
   logic                    inv_sel;
   logic [COUNT_WIDTH-1:0]  clamp_cnt;
   logic [COUNT_WIDTH-1:0]  act_sel;
   logic [COUNT_WIDTH-1:0]  tot_sel;
   logic [MASK_W-1:0]       act_mask;
   logic [MASK_W-1:0]       tot_mask;

   assign accept  = in_valid && in_ready;
   assign load    = accept && (in_total != '0);
   assign advance = out_valid && out_ready && !out_last_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (load) state_d = EMIT;
         EMIT:    if (out_valid && out_ready && out_last_q) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the state register
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == EMIT);
   end

   assign clamp_cnt = (in_count < in_total) ? in_count : in_total;
   assign act_sel   = load ? clamp_cnt : rem_act_q;
   assign tot_sel   = load ? in_total  : rem_tot_q;

`ifdef VMASK_EXPAND_INVERT_EN
   assign inv_sel = load ? in_invert : invert_q;
`else
   assign inv_sel = 1'b0;
`endif

   vmask_thermo #(.MASK_W(MASK_W), .COUNT_WIDTH(COUNT_WIDTH)) u_thermo_act (
      .rem  (act_sel),
      .mask (act_mask)
   );

   vmask_thermo #(.MASK_W(MASK_W), .COUNT_WIDTH(COUNT_WIDTH)) u_thermo_tot (
      .rem  (tot_sel),
      .mask (tot_mask)
   );

   // Each new beat is built from the counts remaining before it, then the counters step past it.
   always_comb begin
      rem_act_d  = rem_act_q;
      rem_tot_d  = rem_tot_q;
      out_m0_d   = out_m0_q;
      out_last_d = out_last_q;
      invert_d   = invert_q;
      if (load || advance) begin
         rem_act_d  = sat_sub(act_sel);
         rem_tot_d  = sat_sub(tot_sel);
         out_m0_d   = inv_sel ? (~act_mask & tot_mask) : (act_mask & tot_mask);
         out_last_d = (tot_sel <= MW_C);
         invert_d   = inv_sel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_act_q  <= '0;
         rem_tot_q  <= '0;
         out_m0_q   <= '0;
         out_last_q <= 1'b0;
         invert_q   <= 1'b0;
      end else begin
         rem_act_q  <= rem_act_d;
         rem_tot_q  <= rem_tot_d;
         out_m0_q   <= out_m0_d;
         out_last_q <= out_last_d;
         invert_q   <= invert_d;
      end
   end

   assign out_m0   = out_m0_q;
   assign out_last = out_last_q;

endmodule

// File: tb/tb_vmask_expand.sv
// Randomized self-checking bench for vmask_expand against a per-element reference model.
module tb_vmask_expand;

   localparam int MW = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_count;
   logic [15:0] in_total;
`ifdef VMASK_EXPAND_INVERT_EN
   logic        in_invert;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_m0;
   logic        out_last;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   vmask_expand #(.REQ_DATA_WIDTH(64), .COUNT_WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_count  (in_count),
      .in_total  (in_total),
`ifdef VMASK_EXPAND_INVERT_EN
      .in_invert (in_invert),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_m0    (out_m0),
      .out_last  (out_last)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Element e of the request is active iff e < min(count,total), complemented within total when inverted.
   function automatic logic [7:0] model_beat(input int c, input int t, input bit inv, input int b);
      logic [7:0] m;
      int act;
      m   = '0;
      act = (c < t) ? c : t;
      for (int i = 0; i < MW; i++) begin
         int e;
         bit on;
         e  = b * MW + i;
         on = (e < act);
         if (inv) on = !on;
         if (e >= t) on = 1'b0;
         m[i] = on;
      end
      return m;
   endfunction

   task automatic run_req(input int c, input int t, input bit inv, input int stall_pct,
                          input int force_beat);
      int nb, beat, cyc, stall_n;
      bit pstall;
      logic [7:0] pm;
      logic pl;
      cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      chk("idle_ready", in_ready, 1);
      in_count = 16'(c);
      in_total = 16'(t);
`ifdef VMASK_EXPAND_INVERT_EN
      in_invert = inv;
`endif
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_count = 16'($urandom);
      in_total = 16'($urandom);
      nb = (t + MW - 1) / MW;
      if (nb == 0) begin
         chk("zero_valid", out_valid, 0);
         chk("zero_ready", in_ready, 1);
         @(posedge clk); #1;
         chk("zero_valid2", out_valid, 0);
         return;
      end
      chk("lat1_valid", out_valid, 1);
      beat = 0; cyc = 0; stall_n = 0; pstall = 0; pm = '0; pl = 0;
      while (beat < nb && cyc < 4000) begin
         if (beat == force_beat && stall_n < 3) begin
            out_ready = 1'b0;
            stall_n++;
         end else begin
            out_ready = ($urandom_range(0, 99) >= stall_pct);
         end
         chk("beat_valid", out_valid, 1);
         chk("busy_ready", in_ready, 0);
         if (pstall) begin
            chk("hold_m0", out_m0, pm);
            chk("hold_last", out_last, pl);
         end
         if (out_ready) begin
            chk($sformatf("m0_c%0d_t%0d_b%0d", c, t, beat), out_m0, model_beat(c, t, inv, beat));
            chk($sformatf("last_b%0d", beat), out_last, (beat == nb - 1));
            beat++;
         end
         pstall = !out_ready;
         pm = out_m0;
         pl = out_last;
         @(posedge clk); #1;
         cyc++;
      end
      out_ready = 1'b0;
      chk("beat_count", beat, nb);
      chk("end_valid", out_valid, 0);
      chk("end_ready", in_ready, 1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_count = '0; in_total = '0;
`ifdef VMASK_EXPAND_INVERT_EN
      in_invert = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_m0", out_m0, 0);
      chk("rst_last", out_last, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_req(5, 8, 0, 0, -1);
      run_req(10, 24, 0, 0, -1);
      run_req(20, 16, 0, 0, -1);
      run_req(0, 16, 0, 0, -1);
      run_req(10, 24, 0, 0, 1);
      run_req(0, 0, 0, 0, -1);
      run_req(7, 0, 0, 0, -1);
      run_req(65535, 20, 0, 20, -1);

      // Abort a request after its first beat.
      in_count = 16'd10; in_total = 16'd24; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_ready", in_ready, 1);
      chk("abort_m0", out_m0, 0);
      chk("abort_last", out_last, 0);
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_quiet", out_valid, 0);
      end
      run_req(3, 8, 0, 0, -1);

`ifdef VMASK_EXPAND_INVERT_EN
      run_req(3, 6, 1, 0, -1);
      run_req(10, 24, 1, 30, -1);
`endif

      for (int k = 0; k < 60; k++) begin
         int c, t;
         bit inv;
         c = ($urandom_range(0, 9) == 0) ? 65535 : $urandom_range(0, 80);
         t = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 70);
`ifdef VMASK_EXPAND_INVERT_EN
         inv = 1'($urandom_range(0, 1));
`else
         inv = 1'b0;
`endif
         run_req(c, t, inv, 35, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vmask_expand.md
VMASK_EXPAND -- requirements
Module: vmask_expand

Interface
REQ-001 SHALL have parameter REQ_DATA_WIDTH, default 64; mask beat width MASK_W = REQ_DATA_WIDTH/8.
REQ-002 SHALL have parameter COUNT_WIDTH, default 16; width of element counts.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, block idle and accepting.
REQ-008 SHALL have port in_count, input, COUNT_WIDTH, number of active (set) elements.
REQ-009 SHALL have port in_total, input, COUNT_WIDTH, total elements to cover.
REQ-010 SHALL have port out_valid, output, 1, mask beat valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts beat.
REQ-012 SHALL have port out_m0, output, MASK_W, mask beat; bit i is element beat*MASK_W+i.
REQ-013 SHALL have port out_last, output, 1, final beat of request.

Function
REQ-014 SHALL accept a request on the cycle in_valid && in_ready; in_ready SHALL equal (state==IDLE).
REQ-015 SHALL use states IDLE and EMIT; IDLE->EMIT on accept with in_total>0; EMIT->IDLE on handshake of the out_last beat.
REQ-016 SHALL, on accept with in_total==0, emit no beats and remain in IDLE.
REQ-017 SHALL present beat 0 with out_valid=1 on the cycle after accept (latency 1); all outputs registered.
REQ-018 SHALL emit ceil(in_total/MASK_W) beats, one per out_valid && out_ready handshake.
REQ-019 SHALL set out_m0 bit i iff element index < min(in_count, in_total); all other bits 0 (thermometer encoding).
REQ-020 SHALL hold out_m0, out_last, out_valid stable while out_valid && !out_ready.
REQ-021 SHALL assert out_last only on the beat containing element in_total-1.
REQ-022 SHALL, on last-beat handshake, drop out_valid next cycle; no back-to-back request accepted in that same cycle (in_ready low while in EMIT).
REQ-023 SHALL track remaining active and remaining total counts in COUNT_WIDTH registers, decremented by MASK_W per beat, saturating at 0 (no wrap-around).
REQ-024 SHALL ignore in_count/in_total changes after accept.

Reset
REQ-025 SHALL, on rst, force state IDLE, out_valid=0, out_last=0, out_m0=0, counters=0, in_ready=1 on the following cycle.
REQ-026 SHALL, on rst mid-EMIT, abort the request silently with no further beats.

Configuration
REQ-027 SHALL, with VMASK_EXPAND_INVERT_EN defined, add input in_invert (1 bit, captured on accept) which complements active bits within in_total; tail bits beyond in_total SHALL remain 0.
REQ-028 SHALL, without VMASK_EXPAND_INVERT_EN, omit in_invert and behave as REQ-019.

Structure
REQ-029 SHALL place the state enum (IDLE, EMIT) and MASK_W derivation in shared package vmask_pkg.
REQ-030 SHALL instantiate sub-module vmask_thermo: combinational remaining-count to MASK_W-bit thermometer mask, used for both active and total masks.

Verification
REQ-031 SHALL cover count=5, total=8, MASK_W=8 -> one beat out_m0=0x1F, out_last=1.
REQ-032 SHALL cover count=10, total=24 -> beats 0xFF, 0x03, 0x00; out_last on third only.
REQ-033 SHALL cover count=20, total=16 -> beats 0xFF, 0xFF (clamped); count=0, total=16 -> 0x00, 0x00.
REQ-034 SHALL cover out_ready low 3 cycles during beat 1 of count=10,total=24 -> 0x03 held stable, no beat lost or duplicated.
REQ-035 SHALL cover rst asserted mid-EMIT -> next cycle out_valid=0, in_ready=1; new request count=3,total=8 yields 0x07.
REQ-036 SHALL cover total=0 accept -> no out_valid, in_ready stays 1; with VMASK_EXPAND_INVERT_EN, count=3,total=6,invert=1 -> 0x38.
